timer_ctrl_master: RTL

- Avalon-MM master that drives the system interval timer from the initiator side.
- Programs the period and control registers, then services the timer IRQ: reads status, clears the timeout, and emits a tick pulse.
- Takes 32-bit counter snapshots on request.
- Sits beside the timer slave in the Qsys fabric and replaces software tick handling for hardware tasks.

---
 rtl/timer_ctrl_master.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master that programs the interval timer, services its IRQ
// and takes 32-bit counter snapshots on request.
module timer_ctrl_master #(
  parameter logic [31:0] DEFAULT_PERIOD = 32'd49999,
  parameter int          TICK_W         = 32,
  parameter bit          CONTINUOUS     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  input  logic [31:0]       period,
  output logic              busy,
  output logic              running,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic [31:0]       snapshot,
  output logic              snap_valid,
  output logic              spurious,
  output logic [2:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [15:0]       avm_writedata,
  input  logic [15:0]       avm_readdata,
  input  logic              irq
);

  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN,
    RD_ST, ST_CAP, CLR_ST, GUARD,
    SNAP_WR, SNAP_RDL, SNAP_RDH, SNAP_CAP,
    STOP_WR
  } state_t;

  localparam logic [15:0] CTL_START =
    {12'd0, 1'b0, 1'b1, CONTINUOUS, 1'b1};
  localparam logic [15:0] CTL_STOP = 16'h0008;

  state_t      state_q, state_d;
  logic [31:0] per_q;
  logic        stop_pend, snap_pend;
  logic [15:0] snap_lo;
  logic        drop_stop, drop_snap;

  always_comb begin
    state_d        = state_q;
    avm_chipselect = 1'b0;
    avm_write_n    = 1'b1;
    avm_address    = 3'd0;
    avm_writedata  = 16'h0000;
    unique case (state_q)
      IDLE: if (start) state_d = WR_PL;
      WR_PL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd2;
        avm_writedata  = per_q[15:0];
        state_d        = WR_PH;
      end
      WR_PH: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd3;
        avm_writedata  = per_q[31:16];
        state_d        = WR_CTL;
      end
      WR_CTL: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = CTL_START;
        state_d        = RUN;
      end
      RUN: begin
        if (irq)                      state_d = RD_ST;
        else if (stop_pend || stop)   state_d = STOP_WR;
        else if (snap_pend || snap_req) state_d = SNAP_WR;
      end
      RD_ST: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd0;
        state_d        = ST_CAP;
      end
      ST_CAP: state_d = avm_readdata[0] ? CLR_ST : GUARD;
      CLR_ST: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd0;
        state_d        = GUARD;
      end
      GUARD: state_d = RUN;
      SNAP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd4;
        state_d        = SNAP_RDL;
      end
      SNAP_RDL: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd4;
        state_d        = SNAP_RDH;
      end
      SNAP_RDH: begin
        avm_chipselect = 1'b1;
        avm_address    = 3'd5;
        state_d        = SNAP_CAP;
      end
      SNAP_CAP: state_d = RUN;
      STOP_WR: begin
        avm_chipselect = 1'b1;
        avm_write_n    = 1'b0;
        avm_address    = 3'd1;
        avm_writedata  = CTL_STOP;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign tick    = (state_q == CLR_ST);
  assign busy    = (state_q != IDLE) && (state_q != RUN);
  assign running = (state_q != IDLE) && (state_q != WR_PL) &&
                   (state_q != WR_PH) && (state_q != WR_CTL) &&
                   (state_q != STOP_WR);

  // a request is consumed when its service starts or the timer stops
  assign drop_stop = (state_q == IDLE) || (state_d == IDLE) ||
                     (state_d == STOP_WR);
  assign drop_snap = (state_q == IDLE) || (state_d == IDLE) ||
                     (state_d == SNAP_WR);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      per_q      <= '0;
      stop_pend  <= 1'b0;
      snap_pend  <= 1'b0;
      snap_lo    <= '0;
      tick_count <= '0;
      snapshot   <= '0;
      snap_valid <= 1'b0;
      spurious   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start)
        per_q <= (period == 32'd0) ? DEFAULT_PERIOD : period;
      if (drop_stop)  stop_pend <= 1'b0;
      else if (stop)  stop_pend <= 1'b1;
      if (drop_snap)     snap_pend <= 1'b0;
      else if (snap_req) snap_pend <= 1'b1;
      if (state_q == ST_CAP && !avm_readdata[0]) spurious <= 1'b1;
      if (state_q == CLR_ST) tick_count <= tick_count + TICK_W'(1);
      if (state_q == SNAP_RDH) snap_lo <= avm_readdata;
      snap_valid <= (state_q == SNAP_CAP);
      if (state_q == SNAP_CAP) snapshot <= {avm_readdata, snap_lo};
    end
  end

endmodule
